regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Two-requester arbiter and init sequencer for the 32x32 single-port on-chip register file (1-cycle read latency, byte-enabled writes).
- Port A is the host control path. Port B is the camera/filter engine reading coefficients at run time.
- After reset, optionally fills every word with INIT_VALUE. It then grants one access per cycle using round-robin and routes read data back to the issuing port.

Parameters:
DATA_W, 32, data width of RAM and requester ports
ADDR_W, 5, word address width
DEPTH, 32, number of words initialised (must be <= 2**ADDR_W)
INIT_ON_RESET, 1, 1 = clear/fill RAM after reset; 0 = skip INIT
INIT_VALUE, 0, word written to every address during INIT

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
a_address  in  ADDR_W  port A word address
a_byteenable  in  DATA_W/8  port A byte enables (writes only)
a_read  in  1  port A read request
a_write  in  1  port A write request
a_writedata  in  DATA_W  port A write data
a_waitrequest  out  1  1 = A's request not accepted this cycle
a_readdata  out  DATA_W  read data to A
a_readdatavalid  out  1  A's read data valid
b_address, b_byteenable, b_read, b_write, b_writedata  in  same widths as A  port B request
b_waitrequest, b_readdata, b_readdatavalid  out  same widths as A  port B response
freeze  in  1  1 = stall: no grants, INIT paused
init_done  out  1  1 once INIT is complete
ram_address  out  ADDR_W  to RAM address
ram_byteenable  out  DATA_W/8  to RAM byteenable
ram_chipselect  out  1  to RAM chipselect
ram_write  out  1  to RAM write
ram_writedata  out  DATA_W  to RAM writedata
ram_clken  out  1  to RAM clken; equals ~freeze
ram_readdata  in  DATA_W  RAM q, valid the cycle after a read is issued

Behaviour:
- Reset values (synchronous, while reset=1 and the cycle after):
  - both waitrequest = 1, both readdatavalid = 0, init_done = 0
  - ram_chipselect = 0, ram_write = 0
  - round-robin pointer = A, init counter = 0
- FSM states: INIT, RUN.
  - Exit from reset goes to INIT if INIT_ON_RESET=1, else RUN.
- INIT:
  - Each non-frozen cycle: chipselect=1, write=1, byteenable all ones, address=counter, writedata=INIT_VALUE; counter increments.
  - After writing address DEPTH-1 (exactly DEPTH write cycles), go to RUN. init_done is registered and goes to 1 on that transition.
  - Both waitrequest = 1 throughout INIT.
- RUN:
  - A port requests when read|write is set. Read and write together is treated as a write; no readdatavalid is generated.
  - One requester only: it is granted in the same cycle (waitrequest=0). RAM signals are driven combinationally from its inputs; chipselect=1; ram_write = its write.
  - Both requesting: grant the port not granted most recently. The other port sees waitrequest=1 and must hold its request.
  - The pointer updates only on a grant.
  - No requester: chipselect=0, both waitrequest=1.
- Read return:
  - A read granted in cycle N gives readdatavalid=1 for exactly cycle N+1, on the issuing port only.
  - Both readdata outputs pass ram_readdata straight through.
  - Back-to-back reads sustain 1 access per cycle.
- freeze=1:
  - ram_clken=0, chipselect=0, both waitrequest=1, INIT counter holds.
  - A read granted in the cycle before freeze still returns readdatavalid in the next cycle.
- Reset mid-INIT or mid-RUN: aborts all activity next edge, drops any pending readdatavalid, restarts INIT.
- Address: no wrap or bounds check in RUN; the address passes through unchanged.

Test Plan:
- INIT_ON_RESET=1, release reset:
  - Exactly 32 consecutive writes of 0x00000000 to addresses 0..31, then init_done=1.
  - A read of address 31 from A returns 0.
- RUN, A writes 0xDEADBEEF to addr 5 with byteenable 4'b0011, after prior content 0x12345678:
  - A reads addr 5 and gets readdatavalid one cycle after grant with data 0x1234BEEF.
  - b_readdatavalid stays 0.
- A and B both read continuously for 6 cycles:
  - Grants alternate A,B,A,B,A,B.
  - Each readdatavalid appears on the correct port one cycle after its grant.
- A writes and B reads the same address in the same cycle:
  - A granted first (pointer=A after reset); B waits one cycle.
  - B's read returns A's new data.
- freeze asserted for 3 cycles mid-INIT at counter=10:
  - No RAM writes during the freeze; INIT resumes at 10; 32 writes total.
  - A read issued the cycle before a freeze still returns its data.
- reset pulsed during RUN with a read in flight:
  - No readdatavalid follows the reset.
  - INIT restarts from address 0.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// One requester port of the register-file arbiter: request from the master, response
// from the arbiter.
interface regfile_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) ();
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter between host (A) and filter engine (B) for a single-port register
// file, with an optional fill of every word after reset.
module regfile_arbiter #(
  parameter int unsigned        DATA_W        = 32,
  parameter int unsigned        ADDR_W        = 5,
  parameter int unsigned        DEPTH         = 32,
  parameter bit                 INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0]  INIT_VALUE    = '0
) (
  input  logic                clk,
  input  logic                reset,
  regfile_arbiter_if.slave    a,
  regfile_arbiter_if.slave    b,
  input  logic                freeze,
  output logic                init_done,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  // StIdle covers the reset cycle and the one after it, when nothing is issued.
  typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              prio_b_q, prio_b_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic              a_req, b_req, a_gnt, b_gnt;

  assign a_req = a.read | a.write;
  assign b_req = b.read | b.write;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    done_d         = done_q;
    prio_b_d       = prio_b_q;
    a_gnt          = 1'b0;
    b_gnt          = 1'b0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (INIT_ON_RESET) begin
            state_d = StInit;
          end else begin
            state_d = StRun;
            done_d  = 1'b1;
          end
        end
        StInit: begin
          if (!freeze) begin
            ram_chipselect = 1'b1;
            ram_write      = 1'b1;
            ram_byteenable = '1;
            ram_address    = cnt_q;
            ram_writedata  = INIT_VALUE;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == LastAddr) begin
              state_d = StRun;
              done_d  = 1'b1;
            end
          end
        end
        StRun: begin
          if (!freeze) begin
            // prio_b_q set means A won last time, so B wins a tie now.
            a_gnt = a_req & (~b_req | ~prio_b_q);
            b_gnt = b_req & ~a_gnt;
            if (a_gnt) begin
              ram_chipselect = 1'b1;
              ram_write      = a.write;
              ram_address    = a.address;
              ram_byteenable = a.byteenable;
              ram_writedata  = a.writedata;
              prio_b_d       = 1'b1;
            end else if (b_gnt) begin
              ram_chipselect = 1'b1;
              ram_write      = b.write;
              ram_address    = b.address;
              ram_byteenable = b.byteenable;
              ram_writedata  = b.writedata;
              prio_b_d       = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Read-with-write counts as a write and produces no return beat.
  assign rvalid_a_d = a_gnt & a.read & ~a.write;
  assign rvalid_b_d = b_gnt & b.read & ~b.write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      prio_b_q   <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      prio_b_q   <= prio_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  assign ram_clken       = ~freeze;
  assign init_done       = done_q & ~reset;
  assign a.waitrequest   = ~a_gnt;
  assign b.waitrequest   = ~b_gnt;
  assign a.readdatavalid = rvalid_a_q & ~reset;
  assign b.readdatavalid = rvalid_b_q & ~reset;
  assign a.readdata      = ram_readdata;
  assign b.readdata      = ram_readdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: bench-side RAM, cycle-level reference model checked on
// every negedge, directed scenarios plus randomized two-port traffic.
module tb_regfile_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, freeze, init_done;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [4:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata, ram_readdata;

  regfile_arbiter_if #(.DATA_W(32), .ADDR_W(5)) a_if ();
  regfile_arbiter_if #(.DATA_W(32), .ADDR_W(5)) b_if ();

  regfile_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .a              (a_if),
    .b              (b_if),
    .freeze         (freeze),
    .init_done      (init_done),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata)
  );

  // Single-port RAM with 1-cycle read latency and byte-enabled writes.
  logic [31:0] ram_mem [32];
  initial begin
    for (int i = 0; i < 32; i++) ram_mem[i] = $urandom;
    ram_readdata = 32'h0;
  end
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int i = 0; i < 4; i++)
          if (ram_byteenable[i]) ram_mem[ram_address][8*i +: 8] <= ram_writedata[8*i +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = quiet cycle after reset, 1 = filling, 2 = serving.
  int          m_phase = 0;
  int          m_cnt = 0;
  bit          m_last_b = 1'b1;   // most recent grantee; B so that A wins the first tie
  bit          m_done = 1'b0;
  bit          m_pend_a = 1'b0, m_pend_b = 1'b0;
  logic [31:0] m_pend_a_data, m_pend_b_data;
  logic [31:0] m_mem [32];

  // Observations used by the directed checks.
  int          wr_seen = 0;
  int          first_wr_addr = -1;
  int          a_rv_cnt = 0, b_rv_cnt = 0;
  logic [31:0] a_last_rd = 32'hFFFF_FFFF, b_last_rd = 32'hFFFF_FFFF;
  bit          gnt_log [$];

  bit          a_req, b_req, ga, gb, e_cs, e_we;
  logic [4:0]  e_addr;
  logic [3:0]  e_be;
  logic [31:0] e_wd;

  always @(negedge clk) begin
    a_req = a_if.read | a_if.write;
    b_req = b_if.read | b_if.write;
    ga = 1'b0; gb = 1'b0;
    e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_be = '0; e_wd = '0;
    if (!reset && !freeze) begin
      if (m_phase == 1) begin
        e_cs = 1'b1; e_we = 1'b1; e_addr = 5'(m_cnt); e_be = 4'hF; e_wd = 32'h0;
      end else if (m_phase == 2) begin
        ga = a_req && (!b_req || m_last_b);
        gb = b_req && !ga;
        if (ga) begin
          e_cs = 1'b1; e_we = a_if.write; e_addr = a_if.address;
          e_be = a_if.byteenable; e_wd = a_if.writedata;
        end else if (gb) begin
          e_cs = 1'b1; e_we = b_if.write; e_addr = b_if.address;
          e_be = b_if.byteenable; e_wd = b_if.writedata;
        end
      end
    end

    chk("a_waitrequest", a_if.waitrequest, !ga);
    chk("b_waitrequest", b_if.waitrequest, !gb);
    chk("a_readdatavalid", a_if.readdatavalid, m_pend_a && !reset);
    chk("b_readdatavalid", b_if.readdatavalid, m_pend_b && !reset);
    if (m_pend_a && !reset) chk("a_readdata", a_if.readdata, m_pend_a_data);
    if (m_pend_b && !reset) chk("b_readdata", b_if.readdata, m_pend_b_data);
    chk("init_done", init_done, m_done && !reset);
    chk("ram_clken", ram_clken, !freeze);
    chk("ram_chipselect", ram_chipselect, e_cs);
    if (reset) chk("ram_write_reset", ram_write, 1'b0);
    if (e_cs) begin
      chk("ram_write", ram_write, e_we);
      chk("ram_address", ram_address, e_addr);
      if (e_we) begin
        chk("ram_byteenable", ram_byteenable, e_be);
        chk("ram_writedata", ram_writedata, e_wd);
      end
    end

    if (!a_if.waitrequest) gnt_log.push_back(1'b0);
    if (!b_if.waitrequest) gnt_log.push_back(1'b1);
    if (a_if.readdatavalid) begin a_rv_cnt++; a_last_rd = a_if.readdata; end
    if (b_if.readdatavalid) begin b_rv_cnt++; b_last_rd = b_if.readdata; end
    if (reset) first_wr_addr = -1;
    else if (ram_clken && ram_chipselect && ram_write) begin
      wr_seen++;
      if (first_wr_addr < 0) first_wr_addr = int'(ram_address);
    end

    // Advance the model to the next cycle.
    m_pend_a = ga && a_if.read && !a_if.write;
    m_pend_b = gb && b_if.read && !b_if.write;
    if (m_pend_a) m_pend_a_data = m_mem[a_if.address];
    if (m_pend_b) m_pend_b_data = m_mem[b_if.address];
    if (reset) begin
      m_phase = 0; m_cnt = 0; m_last_b = 1'b1; m_done = 1'b0;
      m_pend_a = 1'b0; m_pend_b = 1'b0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (!freeze) begin
        m_mem[m_cnt] = 32'h0;
        m_cnt++;
        if (m_cnt == 32) begin m_phase = 2; m_done = 1'b1; end
      end
    end else begin
      if (ga || gb) m_last_b = gb;
      if (e_cs && e_we)
        for (int i = 0; i < 4; i++)
          if (e_be[i]) m_mem[e_addr][8*i +: 8] = e_wd[8*i +: 8];
    end
  end

  // Requests are issued at posedge+1 and held until granted.
  task automatic req_a(input bit rd, input bit wr, input logic [4:0] ad,
                       input logic [3:0] be, input logic [31:0] wd);
    bit g = 1'b0;
    a_if.read = rd; a_if.write = wr; a_if.address = ad;
    a_if.byteenable = be; a_if.writedata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!a_if.waitrequest) begin g = 1'b1; break; end
    end
    @(posedge clk); #1;
    a_if.read = 1'b0; a_if.write = 1'b0;
    chk("a_granted", g, 1'b1);
  endtask

  task automatic req_b(input bit rd, input bit wr, input logic [4:0] ad,
                       input logic [3:0] be, input logic [31:0] wd);
    bit g = 1'b0;
    b_if.read = rd; b_if.write = wr; b_if.address = ad;
    b_if.byteenable = be; b_if.writedata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!b_if.waitrequest) begin g = 1'b1; break; end
    end
    @(posedge clk); #1;
    b_if.read = 1'b0; b_if.write = 1'b0;
    chk("b_granted", g, 1'b1);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic wait_init_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (init_done) begin ok = 1'b1; break; end
    end
    chk("init_done_reached", ok, 1'b1);
    next_cycle();
  endtask

  task automatic rand_a(input int n);
    for (int k = 0; k < n; k++) begin
      int op = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) next_cycle();
      req_a(op != 1, op != 0, 5'($urandom), 4'($urandom), $urandom);
    end
  endtask

  task automatic rand_b(input int n);
    for (int k = 0; k < n; k++) begin
      int op = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) next_cycle();
      req_b(op != 1, op != 0, 5'($urandom), 4'($urandom), $urandom);
    end
  endtask

  initial begin
    int          base;
    bit          ok;
    logic [5:0]  seq;

    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    reset = 1'b1; freeze = 1'b0;
    a_if.read = 0; a_if.write = 0; a_if.address = 0; a_if.byteenable = 0; a_if.writedata = 0;
    b_if.read = 0; b_if.write = 0; b_if.address = 0; b_if.byteenable = 0; b_if.writedata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Fill with a 3-cycle freeze once addresses 0..9 are written.
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (wr_seen == 10) begin ok = 1'b1; break; end
    end
    chk("init_reach_10", ok, 1'b1);
    #1 freeze = 1'b1;
    repeat (3) @(posedge clk);
    #1 freeze = 1'b0;
    chk("init_frozen_writes", wr_seen, 10);
    wait_init_done();
    chk("init_write_count", wr_seen, 32);
    chk("init_first_addr", first_wr_addr, 0);

    req_a(1'b1, 1'b0, 5'd31, 4'h0, 32'h0);
    @(negedge clk); #1;
    chk("a_read31_after_init", a_last_rd, 32'h0);
    next_cycle();

    // Partial byte write merge.
    req_a(1'b0, 1'b1, 5'd5, 4'hF, 32'h1234_5678);
    req_a(1'b0, 1'b1, 5'd5, 4'b0011, 32'hDEAD_BEEF);
    base = b_rv_cnt;
    req_a(1'b1, 1'b0, 5'd5, 4'h0, 32'h0);
    @(negedge clk); #1;
    chk("a_read5_merged", a_last_rd, 32'h1234_BEEF);
    chk("b_rv_quiet", b_rv_cnt, base);
    next_cycle();

    // Both ports reading continuously: B granted alone first, so A wins the first tie.
    req_b(1'b1, 1'b0, 5'd1, 4'h0, 32'h0);
    gnt_log.delete();
    fork
      begin for (int k = 0; k < 3; k++) req_a(1'b1, 1'b0, 5'(k + 4), 4'h0, 32'h0); end
      begin for (int k = 0; k < 3; k++) req_b(1'b1, 1'b0, 5'(k + 20), 4'h0, 32'h0); end
    join
    chk("rr_grant_count", gnt_log.size(), 6);
    seq = '0;
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) seq[i] = gnt_log[i];
    chk("rr_grant_order", seq, 6'b101010);
    next_cycle();

    // Read granted just before a freeze still returns.
    req_a(1'b0, 1'b1, 5'd7, 4'hF, 32'hCAFE_F00D);
    req_a(1'b1, 1'b0, 5'd7, 4'h0, 32'h0);
    freeze = 1'b1;
    @(negedge clk); #1;
    chk("read_across_freeze", a_last_rd, 32'hCAFE_F00D);
    next_cycle();
    next_cycle();
    freeze = 1'b0;

    // Randomized traffic on both ports with sporadic freezes.
    fork
      rand_a(60);
      rand_b(60);
      begin
        repeat (200) begin
          freeze = ($urandom_range(0, 9) == 0);
          next_cycle();
        end
        freeze = 1'b0;
      end
    join
    freeze = 1'b0;
    next_cycle();

    // Reset while a read is in flight.
    a_if.read = 1'b1; a_if.address = 5'd3;
    @(negedge clk);
    chk("flight_grant", !a_if.waitrequest, 1'b1);
    base = a_rv_cnt;
    @(posedge clk); #1;
    reset = 1'b1; a_if.read = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("no_rv_after_reset", a_rv_cnt, base);
    base = wr_seen;
    wait_init_done();
    chk("reinit_write_count", wr_seen - base, 32);
    chk("reinit_first_addr", first_wr_addr, 0);

    // Same-address write (A) and read (B) in the same cycle; pointer favours A.
    gnt_log.delete();
    b_last_rd = 32'hFFFF_FFFF;
    fork
      req_a(1'b0, 1'b1, 5'd9, 4'hF, 32'h55AA_55AA);
      req_b(1'b1, 1'b0, 5'd9, 4'h0, 32'h0);
    join
    @(negedge clk); #1;
    chk("same_addr_grants", gnt_log.size(), 2);
    seq = '0;
    for (int i = 0; i < 2 && i < gnt_log.size(); i++) seq[i] = gnt_log[i];
    chk("same_addr_order", seq[1:0], 2'b10);
    chk("same_addr_b_data", b_last_rd, 32'h55AA_55AA);
    next_cycle();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end
endmodule
